mips_bus_arbiter: RTL

Two-port arbiter sharing the CPU's single Avalon-style memory bus between the instruction-fetch port and the load/store data port of the bus-based MIPS CPU. Each requester issues one word transaction at a time with a req/done handshake. The arbiter drives the master bus, honours `waitrequest`, and captures read data one cycle after acceptance, matching the registered-read memory model. It also rejects misaligned addresses and aborts transactions stalled beyond a timeout.

---
 rtl/mips_bus_pkg.sv | 11 +
 rtl/mips_bus_rr_pick.sv | 11 +
 rtl/mips_bus_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and constants for the MIPS bus arbiter
package mips_bus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, FINISH} state_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  byteenable;
    logic [31:0] wdata;
  } bus_req_t;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
endpackage

// File: rtl/mips_bus_rr_pick.sv
// mips_bus_rr_pick: two-way round-robin grant between fetch and data ports
module mips_bus_rr_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic last_d,
  output logic gnt_i,
  output logic gnt_d
);
  assign gnt_d = d_req & (~i_req | ~last_d);
  assign gnt_i = i_req & ~gnt_d;
endmodule

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: shares one Avalon-style master bus between fetch and load/store ports
module mips_bus_arbiter import mips_bus_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        read,
  output logic        write,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);
  state_t      state, state_nx;
  bus_req_t    win;
  logic        gnt_i, gnt_d, last_d, sel_d, err_q, misaligned, timeout;
  logic [15:0] stall_cnt;
  mips_bus_rr_pick u_pick (
    .i_req (i_req),
    .d_req (d_req),
    .last_d(last_d),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );
  always_comb begin
    win = gnt_d ? bus_req_t'{we: d_we, addr: d_addr, byteenable: d_we ? d_byteenable : 4'b1111, wdata: d_wdata}
                : bus_req_t'{we: 1'b0, addr: i_addr, byteenable: 4'b1111, wdata: 32'h0};
    misaligned = |(win.addr[1:0] & WORD_ALIGN_MASK);
    timeout = (TIMEOUT_CYCLES != 0) && ({16'd0, stall_cnt} + 32'd1 == 32'(TIMEOUT_CYCLES));
    state_nx = state == IDLE  ? ((gnt_i | gnt_d) ? (misaligned ? FINISH : ISSUE) : IDLE) :
               state == ISSUE ? (waitrequest ? (timeout ? FINISH : ISSUE) : (write ? FINISH : RESP)) :
               state == RESP  ? FINISH : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      i_done     <= 1'b0;
      i_err      <= 1'b0;
      i_rdata    <= '0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
      last_d     <= 1'b0;
      sel_d      <= 1'b0;
      err_q      <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      state  <= state_nx;
      i_done <= 1'b0;
      i_err  <= 1'b0;
      d_done <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: if (gnt_i | gnt_d) begin
          sel_d <= gnt_d;
          err_q <= misaligned;
          if (!misaligned) begin
            read       <= !win.we;
            write      <= win.we;
            address    <= win.addr;
            byteenable <= win.byteenable;
            writedata  <= win.wdata;
          end
        end
        ISSUE: if (!waitrequest || timeout) begin
          read  <= 1'b0;
          write <= 1'b0;
          err_q <= waitrequest;
        end else begin
          stall_cnt <= stall_cnt + 16'd1;
        end
        RESP: if (sel_d) d_rdata <= readdata; else i_rdata <= readdata;
        FINISH: begin
          i_done    <= !sel_d;
          d_done    <= sel_d;
          i_err     <= !sel_d && err_q;
          d_err     <= sel_d && err_q;
          last_d    <= sel_d;
          stall_cnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
